// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word reads
// and buffers returned words in a 2-entry prefetch FIFO presented to the decoder.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_take,
  input  logic        pc_ie,
  input  logic [15:0] pc_in
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] head_pc_q, head_pc_d;
  logic [15:0] head_word_q, head_word_d;
  logic [15:0] tail_pc_q, tail_pc_d;
  logic [15:0] tail_word_q, tail_word_d;

  logic pop_s;
  logic redir_s;
  logic push_s;

  assign pop_s   = instr_take && (count_q != 2'd0);
  assign redir_s = pop_s && pc_ie;
  // A word acked in the redirect cycle belongs to the abandoned stream.
  assign push_s  = (state_q == S_REQ) && mem_ack && !redir_s;

  assign mem_req     = (state_q != S_IDLE);
  assign mem_addr    = addr_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = (count_q != 2'd0) ? head_word_q : 16'h0000;
  assign instr_pc    = (count_q != 2'd0) ? head_pc_q   : 16'h0000;

  always_comb begin
    count_d     = count_q;
    fetch_pc_d  = fetch_pc_q;
    head_pc_d   = head_pc_q;
    head_word_d = head_word_q;
    tail_pc_d   = tail_pc_q;
    tail_word_d = tail_word_q;

    if (redir_s) begin
      count_d    = 2'd0;
      fetch_pc_d = pc_in;
    end else begin
      if (push_s && !pop_s) begin
        count_d = count_q + 2'd1;
      end else if (!push_s && pop_s) begin
        count_d = count_q - 2'd1;
      end else begin
        count_d = count_q;
      end
      if (push_s) begin
        fetch_pc_d = fetch_pc_q + 16'd1;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
    end

    if (pop_s && !redir_s) begin
      head_pc_d   = tail_pc_q;
      head_word_d = tail_word_q;
    end else begin
      head_pc_d   = head_pc_q;
      head_word_d = head_word_q;
    end

    // Space rule guarantees count <= 1 at any push, so a push lands in head or tail.
    if (push_s) begin
      if ((count_q == 2'd0) || pop_s) begin
        head_pc_d   = fetch_pc_q;
        head_word_d = mem_data;
      end else begin
        tail_pc_d   = fetch_pc_q;
        tail_word_d = mem_data;
      end
    end else begin
      tail_pc_d   = tail_pc_q;
      tail_word_d = tail_word_q;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (count_d < 2'd2) begin
          state_d = S_REQ;
          addr_d  = fetch_pc_d;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (count_d < 2'd2) begin
            state_d = S_REQ;
            addr_d  = fetch_pc_d;
          end else begin
            state_d = S_IDLE;
          end
        end else if (redir_s) begin
          state_d = S_DISCARD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DISCARD: begin
        // The stale word is dropped; FIFO is empty so a new request always fits.
        if (mem_ack) begin
          state_d = S_REQ;
          addr_d  = fetch_pc_d;
        end else begin
          state_d = S_DISCARD;
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = fetch_pc_d;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      addr_q      <= RESET_PC;
      count_q     <= 2'd0;
      head_pc_q   <= 16'h0000;
      head_word_q <= 16'h0000;
      tail_pc_q   <= 16'h0000;
      tail_word_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      head_pc_q   <= head_pc_d;
      head_word_q <= head_word_d;
      tail_pc_q   <= tail_pc_d;
      tail_word_q <= tail_word_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory, an instruction-stream model
// (expected PC sequence) checked every cycle, plus directed literal checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_take;
  logic        pc_ie;
  logic [15:0] pc_in;

  logic        mem_req2;
  logic [15:0] mem_addr2;
  logic        mem_ack2;
  logic [15:0] mem_data2;
  logic [15:0] instr2;
  logic [15:0] instr_pc2;
  logic        instr_valid2;
  logic        take2 = 1'b1;
  logic        pc_ie2 = 1'b0;
  logic [15:0] pc_in2 = 16'h0000;

  int n_checks = 0;
  int n_fail   = 0;
  int n_taken  = 0;
  int lat      = 0;
  int wcnt     = 0;
  bit rand_lat = 1'b0;

  logic [15:0] exp_pc = 16'h0000;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [15:0] prev_addr = 16'h0000;

  fetch_unit #(.RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_take(instr_take), .pc_ie(pc_ie), .pc_in(pc_in)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_ack2), .mem_data(mem_data2), .instr(instr2), .instr_pc(instr_pc2),
    .instr_valid(instr_valid2), .instr_take(take2), .pc_ie(pc_ie2), .pc_in(pc_in2)
  );

  // Zero-wait memory for the wrap-around instance.
  assign mem_ack2  = mem_req2;
  assign mem_data2 = mem_addr2 ^ 16'hA5A5;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  task automatic mem_drive();
    if (mem_req) begin
      if (wcnt >= lat) begin
        mem_ack  = 1'b1;
        mem_data = mem_addr ^ 16'hA5A5;
        wcnt     = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end else begin
        mem_ack  = 1'b0;
        mem_data = 16'($urandom);
        wcnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      mem_data = 16'($urandom);
      wcnt     = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    wcnt    = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Stream model: every word shown must be the expected PC, data = PC ^ A5A5.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc   = 16'h0000;
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (instr_valid) begin
        chk("stream_pc", instr_pc, exp_pc);
        chk("stream_word", instr, exp_pc ^ 16'hA5A5);
      end else begin
        chk("empty_instr", instr, 16'h0000);
        chk("empty_pc", instr_pc, 16'h0000);
      end
      if (prev_req && !prev_ack) begin
        chk("req_held", {15'd0, mem_req}, 16'h0001);
        chk("addr_held", mem_addr, prev_addr);
      end
      if (instr_valid && instr_take) begin
        n_taken++;
        exp_pc = pc_ie ? pc_in : exp_pc + 16'd1;
      end
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    rst_n = 1'b0; mem_ack = 1'b0; mem_data = 16'h0000;
    instr_take = 1'b0; pc_ie = 1'b0; pc_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {15'd0, mem_req}, 16'h0000);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_valid", {15'd0, instr_valid}, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc", instr_pc, 16'h0000);

    // Zero-wait memory, take held high.
    lat = 0; rand_lat = 1'b0; instr_take = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("c1_req", {15'd0, mem_req}, 16'h0001);
    chk("c1_addr", mem_addr, 16'h0000);
    chk("c1_valid", {15'd0, instr_valid}, 16'h0000);
    tick();
    chk("c2_valid", {15'd0, instr_valid}, 16'h0001);
    chk("c2_pc", instr_pc, 16'h0000);
    chk("c2_instr", instr, 16'hA5A5);
    chk("c2_addr", mem_addr, 16'h0001);
    chk("wrap_pc0", instr_pc2, 16'hFFFE);
    tick();
    chk("c3_pc", instr_pc, 16'h0001);
    chk("c3_addr", mem_addr, 16'h0002);
    chk("wrap_pc1", instr_pc2, 16'hFFFF);
    tick();
    chk("wrap_pc2", instr_pc2, 16'h0000);
    tick();
    chk("wrap_pc3", instr_pc2, 16'h0001);

    // Stall the consumer: FIFO fills to 2 and requests stop.
    instr_take = 1'b0;
    repeat (10) tick();
    chk("stall_req", {15'd0, mem_req}, 16'h0000);
    chk("stall_valid", {15'd0, instr_valid}, 16'h0001);
    instr_take = 1'b1;

    // Random traffic: variable latency, random take and redirects.
    rand_lat = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      tick();
      instr_take = ($urandom_range(0, 9) < 7);
      pc_ie      = ($urandom_range(0, 15) == 0);
      pc_in      = 16'($urandom);
    end
    pc_ie = 1'b0;
    chk("progress", {15'd0, (n_taken >= 200) ? 1'b1 : 1'b0}, 16'h0001);

    // Latency 3: redirect to 0x0100 while the read of 0x0005 is outstanding.
    rand_lat = 1'b0; lat = 3; instr_take = 1'b1;
    do_reset();
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      if (mem_req && mem_addr == 16'h0005 && !mem_ack && instr_valid) begin
        instr_take = 1'b1; pc_ie = 1'b1; pc_in = 16'h0100;
        done = 1'b1;
      end else begin
        instr_take = (instr_pc <= 16'h0003);
      end
    end
    if (!done) timeout("wait_addr5");
    tick();
    pc_ie = 1'b0; instr_take = 1'b1;
    chk("disc_valid", {15'd0, instr_valid}, 16'h0000);
    chk("disc_req", {15'd0, mem_req}, 16'h0001);
    chk("disc_addr", mem_addr, 16'h0005);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (mem_ack) done = 1'b1;
      else tick();
    end
    if (!done) timeout("wait_disc_ack");
    tick();
    chk("redir_addr", mem_addr, 16'h0100);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (instr_valid) begin
        chk("redir_first_pc", instr_pc, 16'h0100);
        done = 1'b1;
      end
    end
    if (!done) timeout("wait_redir_valid");

    // Zero-wait: redirect in the same cycle as an ack.
    lat = 0;
    repeat (3) tick();
    chk("same_pre", {14'd0, instr_valid, mem_ack}, 16'h0003);
    pc_ie = 1'b1; pc_in = 16'h0200;
    tick();
    pc_ie = 1'b0;
    chk("same_valid", {15'd0, instr_valid}, 16'h0000);
    chk("same_req", {15'd0, mem_req}, 16'h0001);
    chk("same_addr", mem_addr, 16'h0200);
    tick();
    chk("same_first_pc", instr_pc, 16'h0200);

    // Latency 2: asynchronous reset in the middle of an outstanding read.
    lat = 2; instr_take = 1'b0;
    do_reset();
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (mem_req && !mem_ack && instr_valid) done = 1'b1;
    end
    if (!done) timeout("wait_mid_req");
    #2;
    rst_n = 1'b0; mem_ack = 1'b0; wcnt = 0;
    #1;
    chk("async_req", {15'd0, mem_req}, 16'h0000);
    chk("async_valid", {15'd0, instr_valid}, 16'h0000);
    chk("async_addr", mem_addr, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1; instr_take = 1'b1;
    tick();
    chk("restart_req", {15'd0, mem_req}, 16'h0001);
    chk("restart_addr", mem_addr, 16'h0000);
    chk("restart_valid", {15'd0, instr_valid}, 16'h0000);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (instr_valid) begin
        chk("restart_first_pc", instr_pc, 16'h0000);
        done = 1'b1;
      end
    end
    if (!done) timeout("wait_restart_valid");
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pcpu core. It owns the fetch program counter, issues word reads to instruction memory over a single-outstanding req/ack handshake, and buffers returned words in a 2-entry prefetch FIFO. It presents one 16-bit instruction word per cycle to the combinational decoder. It consumes the decoder's pc_ie / jump-target result to flush and redirect the fetch stream.

## Interface
- RESET_PC, 16'h0000, address of the first fetch after reset
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_req  out  1  read request to instruction memory
- mem_addr  out  16  word address of request; stable while mem_req=1 and no ack
- mem_ack  in  1  one-cycle pulse; mem_data valid in the same cycle
- mem_data  in  16  returned instruction word
- instr  out  16  FIFO head word to decoder; 16'h0000 (nop) when empty
- instr_pc  out  16  address of instr; 16'h0000 when empty
- instr_valid  out  1  FIFO non-empty
- instr_take  in  1  core executed instr this cycle; ignored when instr_valid=0
- pc_ie  in  1  jump taken by current instr; sampled only when instr_take=1 and instr_valid=1
- pc_in  in  16  jump target; sampled with pc_ie

## Operation
- State: fetch_pc[15:0], FIFO of 2 entries {pc, word}, count[1:0], FSM {IDLE, REQ, DISCARD}.
- IDLE -> REQ when count + (0 outstanding) < 2; drives mem_req=1, mem_addr=fetch_pc.
- REQ, mem_ack=1: push {fetch_pc, mem_data}; fetch_pc <= fetch_pc+1 (16-bit wrap, FFFF->0000). Stay in REQ if space remains after this cycle's push/pop, else go to IDLE.
- REQ, mem_ack=0: hold mem_req and mem_addr unchanged. A request is never withdrawn.
- Space rule: a new request issues only if count after this edge is < 2. Pushes never overflow.
- Pop: instr_take=1 with instr_valid=1 removes the head. Push and pop in the same cycle leave count unchanged.
- Redirect: take with pc_ie=1:
  - FIFO is flushed (count <= 0) and fetch_pc <= pc_in.
  - If a request is outstanding and mem_ack=0 this cycle, go to DISCARD.
  - If mem_ack=1 in the same cycle, the returned word is dropped and the next state is REQ at pc_in.
- DISCARD: keep mem_req=1 with the old mem_addr until mem_ack, then drop the data. Next cycle go to REQ at pc_in.
- A second redirect while in DISCARD only updates fetch_pc. The state stays DISCARD.
- No pc_ie with take: sequential flow; the FIFO already holds the successor.

## Timing
- Reset (async, immediate): mem_req=0, mem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, count=0, fetch_pc=RESET_PC, FSM=IDLE. Any in-flight memory request is abandoned; the memory side must tolerate this.
- First rising edge after rst_n release: FSM=REQ, so mem_req=1 at RESET_PC in cycle 1.
- Memory latency L cycles (ack L cycles after req rises; L=0 means ack in the same cycle). instr_valid rises the cycle after ack.
- Zero-wait memory: sustained 1 instr/cycle with continuous take.
- Redirect penalty, zero-wait memory, no outstanding request at the redirect edge: target word valid 2 cycles after the take edge (request cycle, then push).
- All outputs come from registers except instr, instr_pc and instr_valid, which come from FIFO head registers. No combinational path from mem_data to instr.
- pc_ie/pc_in may combinationally depend on instr. No combinational path from pc_ie to any output.

## Test plan
- Reset, zero-wait mem returning addr^16'hA5A5, take held high: mem_addr 0,1,2,… on consecutive cycles; instr_valid from cycle 2; instr_pc increments by 1 each cycle; instr=instr_pc^A5A5.
- take low for 10 cycles: exactly 2 words buffered, mem_req=0 afterwards, no lost or duplicate words when take resumes.
- Memory latency 3, redirect to 16'h0100 while request for 0x0005 outstanding: 0x0005 data dropped (never on instr), next mem_addr=0x0100, first valid instr_pc=0x0100.
- Redirect on same cycle as mem_ack: acked word discarded, FIFO empty next cycle, mem_addr=pc_in following cycle.
- RESET_PC=16'hFFFE, sequential fetch: instr_pc sequence FFFE, FFFF, 0000, 0001.
- rst_n pulsed low mid-REQ with latency 2: mem_req and instr_valid drop asynchronously; after release, fetch restarts at RESET_PC with empty FIFO.
